// File: rtl/phys_mem_responder.sv
// Physical-memory endpoint for the TLB-driven 48-bit memory bus: word RAM plus a device
// register bank, with configurable wait states and fault reporting on the shared data bus.
module phys_mem_responder #(
    parameter int RAM_WORDS = 4096,
    parameter int DEV_WORDS = 16,
    parameter int LATENCY   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_mem_address,
    input  logic        i_device_space,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    output logic        o_mem_valid,
    inout  wire  [31:0] io_mem_data,
    output logic        o_bus_error,
    output logic [31:0] o_cycle_count
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int DEV_AW = $clog2(DEV_WORDS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [45:0]       index;
    logic              dev_sel;
    logic              rd_req;
    logic              wr_req;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [31:0]       ram      [RAM_WORDS];
    logic [31:0]       dev_regs [DEV_WORDS];

    logic              ram_hit;
    logic              dev_hit;
    logic              fault;
    logic              abort;
    logic              hold;
    logic              access;
    logic              ram_we;
    logic              dev_we;
    logic [31:0]       dev_rd;
    logic [RAM_AW-1:0] ram_idx;
    logic [DEV_AW-1:0] dev_idx;

    // Byte-lane bits are not part of the word index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_mem_address[1:0];

    assign ram_idx = index[RAM_AW-1:0];
    assign dev_idx = index[DEV_AW-1:0];

    assign io_mem_data = (i_mem_read && o_mem_valid) ? rdata : 'z;

    always_comb begin
        ram_hit = index < 46'(RAM_WORDS);
        dev_hit = index < 46'(DEV_WORDS);
        fault   = (rd_req && wr_req)
                || (dev_sel ? !dev_hit : !ram_hit)
                || (dev_sel && wr_req && dev_idx == '0);
        abort   = !i_mem_read && !i_mem_write;
        // Response is held only by the strobe that started the transaction.
        hold    = (rd_req && i_mem_read) || (wr_req && i_mem_write);
        access  = (state == WAIT) && !abort && (wait_cnt == '0);
        ram_we  = access && wr_req && !dev_sel && !fault;
        dev_we  = access && wr_req && dev_sel && !fault;
        dev_rd  = (dev_idx == '0) ? o_cycle_count : dev_regs[dev_idx];
    end

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            ram[ram_idx] <= wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            index         <= '0;
            dev_sel       <= 1'b0;
            rd_req        <= 1'b0;
            wr_req        <= 1'b0;
            wdata         <= '0;
            rdata         <= '0;
            o_mem_valid   <= 1'b0;
            o_bus_error   <= 1'b0;
            o_cycle_count <= '0;
            for (int unsigned i = 0; i < DEV_WORDS; i++) begin
                dev_regs[i] <= '0;
            end
        end else begin
            o_cycle_count <= o_cycle_count + 32'd1;
            if (dev_we) begin
                dev_regs[dev_idx] <= wdata;
            end
            case (state)
                IDLE: begin
                    if (i_mem_read || i_mem_write) begin
                        index    <= i_mem_address[47:2];
                        dev_sel  <= i_device_space;
                        rd_req   <= i_mem_read;
                        wr_req   <= i_mem_write;
                        wdata    <= io_mem_data;
                        wait_cnt <= CNT_W'(LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        o_mem_valid <= 1'b1;
                        o_bus_error <= fault;
                        rdata       <= (rd_req && !fault) ? (dev_sel ? dev_rd : ram[ram_idx]) : '0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (!hold) begin
                        o_mem_valid <= 1'b0;
                        o_bus_error <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phys_mem_responder.sv
// Directed bench for phys_mem_responder: RAM/device accesses, faults, abort and async reset.
module tb_phys_mem_responder;
    localparam int RAM_WORDS = 4096;
    localparam int DEV_WORDS = 16;
    localparam int LATENCY   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] addr;
    logic        dev;
    logic        rd;
    logic        wr;
    logic        valid;
    logic        err;
    logic [31:0] cyc_out;
    logic        drive;
    logic [31:0] wdat;
    wire  [31:0] bus;

    assign bus = drive ? wdat : 'z;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] cyc_model;
    logic [31:0] last_data;
    logic        last_err;
    int          last_lat;
    logic [31:0] last_cyc;

    phys_mem_responder #(
        .RAM_WORDS(RAM_WORDS),
        .DEV_WORDS(DEV_WORDS),
        .LATENCY  (LATENCY)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mem_address (addr),
        .i_device_space(dev),
        .i_mem_read    (rd),
        .i_mem_write   (wr),
        .o_mem_valid   (valid),
        .io_mem_data   (bus),
        .o_bus_error   (err),
        .o_cycle_count (cyc_out)
    );

    always #5 clk = ~clk;

    // Reference free-running counter: cleared by reset, +1 on every edge.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc_model <= '0;
        else     cyc_model <= cyc_model + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One handshake; address/data are scrambled after acceptance to show they were latched.
    task automatic xfer(input logic r, input logic w, input logic d,
                        input logic [47:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        rd = r; wr = w; dev = d; addr = a; wdat = wd; drive = w && !r;
        @(posedge clk);
        @(negedge clk);
        addr = a ^ 48'h0000_0000_0150;
        wdat = ~wd;
        n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!valid) begin
            check("valid_timeout", {31'd0, valid}, 32'd1);
            rd = 0; wr = 0; drive = 0;
            last_data = '0; last_err = 1'b0; last_lat = n; last_cyc = cyc_model;
            @(negedge clk);
        end else begin
            last_lat  = n;
            last_data = bus;
            last_err  = err;
            last_cyc  = cyc_model;
            @(negedge clk);
            check("hold_valid", {31'd0, valid}, 32'd1);
            if (r) check("hold_data", bus, last_data);
            rd = 0; wr = 0; drive = 0;
            @(negedge clk);
            check("release_valid", {31'd0, valid}, 32'd0);
            check("release_err", {31'd0, err}, 32'd0);
            if (r) begin
                drive = 1; wdat = 32'h5A5A_A5A5;
                #1;
                check("bus_released", bus, 32'h5A5A_A5A5);
                drive = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] d1, d2, c1;
        logic        seen;
        int          n;
        rst = 1; rd = 0; wr = 0; dev = 0; addr = '0; drive = 0; wdat = '0;
        #12;
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_cycle", cyc_out, 32'd0);
        @(negedge clk);
        rst = 0;

        // RAM write/read and latency
        xfer(0, 1, 0, 48'h40, 32'hDEAD_BEEF);
        check("wr_latency", 32'(last_lat), 32'(LATENCY));
        check("wr_err", {31'd0, last_err}, 32'd0);
        xfer(1, 0, 0, 48'h40, '0);
        check("rd_latency", 32'(last_lat), 32'(LATENCY));
        check("rd_data", last_data, 32'hDEAD_BEEF);
        check("rd_err", {31'd0, last_err}, 32'd0);
        xfer(0, 1, 0, 48'h3FFC, 32'hCAFE_F00D);
        xfer(1, 0, 0, 48'h3FFC, '0);
        check("ram_last_word", last_data, 32'hCAFE_F00D);
        check("ram_last_err", {31'd0, last_err}, 32'd0);

        // Out of range
        xfer(1, 0, 0, 48'(4 * RAM_WORDS), '0);
        check("oor_err", {31'd0, last_err}, 32'd1);
        check("oor_data", last_data, 32'd0);
        xfer(1, 0, 0, 48'h40, '0);
        check("after_oor_err", {31'd0, last_err}, 32'd0);
        check("after_oor_data", last_data, 32'hDEAD_BEEF);
        xfer(1, 0, 0, 48'h8000_0000_0040, '0);
        check("oor_high_err", {31'd0, last_err}, 32'd1);
        xfer(0, 1, 0, 48'h4000_0000_0040, 32'h7777_7777);
        check("oor_wr_err", {31'd0, last_err}, 32'd1);
        xfer(1, 0, 0, 48'h40, '0);
        check("oor_wr_no_commit", last_data, 32'hDEAD_BEEF);

        // Device bank
        xfer(0, 1, 1, 48'hC, 32'h1234_5678);
        check("dev_wr_err", {31'd0, last_err}, 32'd0);
        xfer(1, 0, 1, 48'hC, '0);
        check("dev3_data", last_data, 32'h1234_5678);
        xfer(0, 1, 1, 48'h3C, 32'hA5A5_0F0F);
        xfer(1, 0, 1, 48'h3C, '0);
        check("dev15_data", last_data, 32'hA5A5_0F0F);
        xfer(1, 0, 1, 48'(4 * DEV_WORDS), '0);
        check("dev_oor_err", {31'd0, last_err}, 32'd1);
        xfer(0, 1, 1, 48'h0, 32'hFFFF_0000);
        check("dev0_wr_err", {31'd0, last_err}, 32'd1);
        check("cycle_unaffected", cyc_out, cyc_model);

        // Cycle counter via register 0
        xfer(1, 0, 1, 48'h0, '0);
        d1 = last_data; c1 = last_cyc;
        check("reg0_read1", d1, c1 - 32'd1);
        repeat (10) @(negedge clk);
        xfer(1, 0, 1, 48'h0, '0);
        d2 = last_data;
        check("reg0_read2", d2, last_cyc - 32'd1);
        check("reg0_delta", d2 - d1, 32'd16);

        // Abort before valid
        xfer(0, 1, 0, 48'h8, 32'h0123_4567);
        @(negedge clk);
        wr = 1; rd = 0; dev = 0; addr = 48'h8; drive = 1; wdat = 32'hAAAA_5555;
        @(posedge clk);
        @(negedge clk);
        wr = 0; drive = 0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | valid;
        end
        check("abort_no_valid", {31'd0, seen}, 32'd0);
        xfer(1, 0, 0, 48'h8, '0);
        check("abort_no_write", last_data, 32'h0123_4567);

        // Simultaneous strobes
        xfer(1, 1, 0, 48'h40, 32'h0BAD_F00D);
        check("both_err", {31'd0, last_err}, 32'd1);
        check("both_data", last_data, 32'd0);
        xfer(1, 0, 0, 48'h40, '0);
        check("both_no_write", last_data, 32'hDEAD_BEEF);

        // Async reset during a response, then during a pending write
        xfer(0, 1, 0, 48'h100, 32'h1111_1111);
        @(negedge clk);
        rd = 1; dev = 0; addr = 48'(4 * RAM_WORDS);
        n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_valid", {31'd0, valid}, 32'd1);
        check("pre_rst_err", {31'd0, err}, 32'd1);
        #2 rst = 1;
        #1;
        check("rst_async_valid", {31'd0, valid}, 32'd0);
        check("rst_async_err", {31'd0, err}, 32'd0);
        check("rst_async_cycle", cyc_out, 32'd0);
        rd = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        wr = 1; dev = 0; addr = 48'h100; drive = 1; wdat = 32'h2222_2222;
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("rst_wait_valid", {31'd0, valid}, 32'd0);
        wr = 0; drive = 0;
        @(negedge clk);
        rst = 0;
        #1;
        check("cycle_restart", cyc_out, 32'd0);
        for (int i = 1; i < DEV_WORDS; i++) begin
            xfer(1, 0, 1, 48'(4 * i), '0);
            check($sformatf("dev%0d_cleared", i), last_data, 32'd0);
        end
        xfer(1, 0, 0, 48'h100, '0);
        check("rst_write_dropped", last_data, 32'h1111_1111);
        xfer(1, 0, 1, 48'h0, '0);
        check("reg0_after_rst", last_data, last_cyc - 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
